read_cmd_scheduler: RTL
=======================

Name: read_cmd_scheduler

Overview:
Round-robin scheduler that shares one DataMover MM2S read-command channel between NUM_REQ requesters. It packs each granted request into the 72-bit read command, using the requester index as the command tag. It also tracks outstanding commands against a credit limit and routes each returned 8-bit status word back to its requester as a done/error pulse. It sits between the per-stream read-command generators and the DataMover command/status ports.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16 (tag field is 4 bits)
MAX_OUTSTANDING, 4, maximum commands issued without a returned status; legal range 1..15
TIMEOUT_CYCLES, 65535, watchdog limit in cycles; used only with READ_SCHED_WATCHDOG_EN

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
req_addr  in  32*NUM_REQ  per-requester byte address; slice i = [32*i+31:32*i]
req_btt  in  23*NUM_REQ  per-requester bytes to transfer; slice i = [23*i+22:23*i]
req_tvalid  in  NUM_REQ  per-requester request valid
req_tready  out  NUM_REQ  per-requester accept; one-hot or zero
command_out_tdata  out  72  DataMover read command
command_out_tvalid  out  1  command valid
command_out_tready  in  1  command accept
status_in_tdata  in  8  DataMover status: [7] okay, [6] slverr, [5] decerr, [4] interr, [3:0] tag
status_in_tvalid  in  1  status valid
status_in_tready  out  1  status accept; tied 1 after reset
done_valid  out  NUM_REQ  one-cycle pulse, bit = returned tag
done_error  out  NUM_REQ  qualified by done_valid; 1 = status reported an error
outstanding  out  4  current outstanding command count
sched_error  out  1  sticky: unexpected status seen
timeout  out  1  sticky watchdog flag; constant 0 without the macro

Behaviour:
- Reset: command_out_tvalid=0, command_out_tdata=0, req_tready=0, done_valid=0, done_error=0, outstanding=0, sched_error=0, timeout=0, rr pointer=0, state=IDLE. status_in_tready is 0 during reset and 1 otherwise.
- FSM has two states, IDLE and ISSUE.
- IDLE, grant rule:
  - Eligible when any req_tvalid=1 and outstanding < MAX_OUTSTANDING.
  - Grant goes to the first set req_tvalid searching upward from the rr pointer, wrapping NUM_REQ-1 -> 0.
  - The granted bit of req_tready is 1 in that same cycle; req_tready is combinational from state, outstanding, pointer and req_tvalid. This is the request handshake.
  - Same edge: command register loads, rr pointer <= grant+1 (wrapping), state -> ISSUE.
  - If not eligible: remain in IDLE, req_tready=0.
- ISSUE: command_out_tvalid=1 and command_out_tdata held stable. On command_out_tready=1: outstanding increments, state -> IDLE, command_out_tvalid drops next cycle.
- Throughput: at most 1 command per 2 cycles. Request handshake to command_out_tvalid latency is 1 cycle.
- Command format, MSB to LSB:
  - {4'b0 rsvd, tag[3:0]=grant index, addr[31:0]=req_addr unmodified, drr=0, eof=1, dsa=6'b0, type=1 (INC), btt[22:0]=req_btt}.
- Status path:
  - Every cycle with status_in_tvalid=1 is accepted.
  - If tag < NUM_REQ and outstanding > 0: done_valid[tag] pulses next cycle. done_error[tag] = (okay==0) or any of [6:4] set. outstanding decrements.
  - If tag >= NUM_REQ or outstanding == 0: set sched_error; no done pulse; count unchanged.
- Simultaneous command handshake and valid status in one cycle: outstanding unchanged.
- Credit boundary:
  - outstanding == MAX_OUTSTANDING blocks new grants.
  - A status in the IDLE cycle does not unblock that same cycle; the grant happens on the next cycle.
- A requester dropping req_tvalid while not granted is legal. Once req_tready is seen, the request is consumed.
- Reset mid-ISSUE: the command is dropped, count cleared, and later statuses for it raise sched_error (system reset also resets the DataMover).

Optional Feature:
READ_SCHED_WATCHDOG_EN
- Defined:
  - A counter runs while outstanding > 0 and clears on any accepted status or when outstanding == 0.
  - When it reaches TIMEOUT_CYCLES, the sticky timeout flag sets and the counter saturates.
  - Only areset clears timeout; scheduling continues unchanged.
- Undefined: no counter logic; timeout tied 0.

Test Plan:
1. Single request: req 2 valid with addr=0x1000_0800, btt=0x400 -> req_tready[2] pulses 1 cycle, next cycle command_out_tdata = {8'h02, 32'h1000_0800, 1'b0, 1'b1, 6'h0, 1'b1, 23'h400}, held until tready. Status 8'h82 -> done_valid[2]=1, done_error[2]=0, outstanding returns to 0.
2. All 4 requesters valid continuously, command_out_tready=1, status returned promptly -> grant order 0,1,2,3,0,1,... with commands every 2 cycles.
3. MAX_OUTSTANDING=4 with no status -> exactly 4 commands issued, then req_tready stays 0. One status 8'h80 -> the next grant occurs within 2 cycles.
4. Status 8'hA1 (decerr, tag 1) -> done_valid[1]=1, done_error[1]=1. Status tag 5 with NUM_REQ=4 -> sched_error=1, no done pulse.
5. Same-cycle command handshake and status -> outstanding unchanged. Assert areset mid-ISSUE -> all outputs return to reset values on the next edge.
6. With READ_SCHED_WATCHDOG_EN, TIMEOUT_CYCLES=16, one command and no status -> timeout=1 after 16 cycles. Without the macro -> timeout stays 0.

Source files
------------

// File: rtl/read_cmd_scheduler.sv
// Round-robin arbiter sharing one DataMover MM2S read-command channel, with credit tracking and status routing.
// Optional watchdog is enabled by defining READ_SCHED_WATCHDOG_EN.
module read_cmd_scheduler #(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 65535
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic [32*NUM_REQ-1:0]  req_addr,
   input  logic [23*NUM_REQ-1:0]  req_btt,
   input  logic [NUM_REQ-1:0]     req_tvalid,
   output logic [NUM_REQ-1:0]     req_tready,
   output logic [71:0]            command_out_tdata,
   output logic                   command_out_tvalid,
   input  logic                   command_out_tready,
   input  logic [7:0]             status_in_tdata,
   input  logic                   status_in_tvalid,
   output logic                   status_in_tready,
   output logic [NUM_REQ-1:0]     done_valid,
   output logic [NUM_REQ-1:0]     done_error,
   output logic [3:0]             outstanding,
   output logic                   sched_error,
   output logic                   timeout
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t               state_reg;
   logic [3:0]           ptr_reg;
   logic [71:0]          command_reg;
   logic                 command_valid_reg;
   logic [3:0]           outstanding_reg;
   logic                 sched_error_reg;
   logic [NUM_REQ-1:0]   done_valid_reg;
   logic [NUM_REQ-1:0]   done_error_reg;

   logic [3:0]           cand_idx [NUM_REQ];
   logic                 grant_found;
   logic [3:0]           grant_idx;
   logic [3:0]           ptr_next;
   logic                 eligible;
   logic [31:0]          grant_addr;
   logic [22:0]          grant_btt;
   logic [NUM_REQ-1:0]   grant_onehot;
   logic [NUM_REQ-1:0]   tag_hit;

   logic [3:0]           status_tag;
   logic                 status_err;
   logic                 status_ok;
   logic                 status_bad;
   logic                 cmd_fire;

   // Candidate i is the requester i positions above the round-robin pointer.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [4:0] sum;
         assign sum          = {1'b0, ptr_reg} + 5'(gi);
         assign cand_idx[gi] = (sum >= 5'(NUM_REQ)) ? 4'(sum - 5'(NUM_REQ)) : sum[3:0];
      end
   endgenerate

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = 4'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && cand_idx[k] == 4'(i) && req_tvalid[i]) begin
               grant_found = 1'b1;
               grant_idx   = 4'(i);
            end
         end
      end
   end

   assign eligible = (state_reg == IDLE) && (outstanding_reg < 4'(MAX_OUTSTANDING)) && grant_found;
   assign ptr_next = (grant_idx == 4'(NUM_REQ - 1)) ? 4'd0 : grant_idx + 4'd1;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
         assign grant_onehot[gi] = eligible && (grant_idx == 4'(gi));
         assign tag_hit[gi]      = (status_tag == 4'(gi));
      end
   endgenerate

   always_comb begin
      grant_addr = 32'd0;
      grant_btt  = 23'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == 4'(i)) begin
            grant_addr = req_addr[32*i +: 32];
            grant_btt  = req_btt[23*i +: 23];
         end
      end
   end

   assign status_tag = status_in_tdata[3:0];
   assign status_err = !status_in_tdata[7] || (|status_in_tdata[6:4]);
   assign status_ok  = status_in_tvalid && ({1'b0, status_tag} < 5'(NUM_REQ)) && (outstanding_reg != 4'd0);
   assign status_bad = status_in_tvalid && !status_ok;
   assign cmd_fire   = command_valid_reg && command_out_tready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg         <= IDLE;
         ptr_reg           <= 4'd0;
         command_reg       <= 72'd0;
         command_valid_reg <= 1'b0;
         outstanding_reg   <= 4'd0;
         sched_error_reg   <= 1'b0;
         done_valid_reg    <= '0;
         done_error_reg    <= '0;
      end else begin
         done_valid_reg <= '0;
         done_error_reg <= '0;

         case (state_reg)
            IDLE: begin
               if (eligible) begin
                  // Command layout: rsvd, tag, addr, drr, eof, dsa, type, btt.
                  command_reg       <= {4'b0, grant_idx, grant_addr, 1'b0, 1'b1, 6'b0, 1'b1, grant_btt};
                  command_valid_reg <= 1'b1;
                  ptr_reg           <= ptr_next;
                  state_reg         <= ISSUE;
               end
            end
            ISSUE: begin
               if (command_out_tready) begin
                  command_valid_reg <= 1'b0;
                  state_reg         <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (cmd_fire && !status_ok)
            outstanding_reg <= outstanding_reg + 4'd1;
         else if (!cmd_fire && status_ok)
            outstanding_reg <= outstanding_reg - 4'd1;

         if (status_ok) begin
            done_valid_reg <= tag_hit;
            done_error_reg <= status_err ? tag_hit : '0;
         end
         if (status_bad)
            sched_error_reg <= 1'b1;
      end
   end

`ifdef READ_SCHED_WATCHDOG_EN
   logic [16:0] wd_cnt_reg;
   logic        timeout_reg;
   logic        wd_clear;

   assign wd_clear = status_in_tvalid || (outstanding_reg == 4'd0);

   // Counter saturates at the limit; the flag is sticky until reset.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wd_cnt_reg  <= 17'd0;
         timeout_reg <= 1'b0;
      end else begin
         if (wd_clear)
            wd_cnt_reg <= 17'd0;
         else if (wd_cnt_reg != 17'(TIMEOUT_CYCLES))
            wd_cnt_reg <= wd_cnt_reg + 17'd1;
         if (!wd_clear && (wd_cnt_reg + 17'd1 >= 17'(TIMEOUT_CYCLES)))
            timeout_reg <= 1'b1;
      end
   end

   assign timeout = timeout_reg;
`else
   assign timeout = 1'b0;
`endif

   assign req_tready         = grant_onehot;
   assign command_out_tdata  = command_reg;
   assign command_out_tvalid = command_valid_reg;
   assign status_in_tready   = !areset;
   assign done_valid         = done_valid_reg;
   assign done_error         = done_error_reg;
   assign outstanding        = outstanding_reg;
   assign sched_error        = sched_error_reg;

endmodule
